// File: rtl/kplic_int_conditioner.sv
// Conditions raw asynchronous interrupt lines into clean active-high KPLIC-domain levels.
// Optional per-line glitch filter is compiled in by defining KPLIC_INT_FILTER_EN.
`timescale 1ns/1ps
module kplic_int_conditioner #(
   parameter int INT_NUM    = 32,
   parameter int FILT_WIDTH = 4
) (
   input  logic                  kplic_clk,
   input  logic                  kplic_rstn,
   input  logic [INT_NUM-1:0]    raw_int,
   input  logic [INT_NUM-1:0]    int_polarity,
   input  logic [FILT_WIDTH-1:0] filt_thresh,
   output logic [INT_NUM-1:0]    external_int,
   output logic [INT_NUM-1:0]    int_status
);

   logic [INT_NUM-1:0] sync1_q;
   logic [INT_NUM-1:0] sync2_q;
   logic [1:0]         settle_q;
   logic [1:0]         settle_d;
   logic               ready;
   logic [INT_NUM-1:0] cond;

   always_ff @(posedge kplic_clk or negedge kplic_rstn) begin
      if (!kplic_rstn) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         settle_q <= '0;
      end else begin
         sync1_q  <= raw_int;
         sync2_q  <= sync1_q;
         settle_q <= settle_d;
      end
   end

   // Outputs stay quiet until the sync chain holds real samples, so an idle-high
   // active-low source cannot fire spuriously at reset release.
   assign ready      = (settle_q == 2'd2);
   assign settle_d   = ready ? settle_q : settle_q + 2'd1;
   assign cond       = sync2_q ^ int_polarity;
   assign int_status = ready ? cond : '0;

`ifdef KPLIC_INT_FILTER_EN
   logic [INT_NUM-1:0][FILT_WIDTH-1:0] cnt_q;
   logic [INT_NUM-1:0][FILT_WIDTH-1:0] cnt_d;
   logic [INT_NUM-1:0]                 filt_q;
   logic [INT_NUM-1:0]                 filt_d;

   // A line flips only after cond has disagreed with filt_q for more than filt_thresh
   // cycles; the >= test lets a lowered threshold take effect on the next mismatch.
   always_comb begin
      cnt_d  = '0;
      filt_d = '0;
      if (ready) begin
         filt_d = filt_q;
         for (int i = 0; i < INT_NUM; i++) begin
            if (cond[i] == filt_q[i]) begin
               cnt_d[i] = '0;
            end else if (cnt_q[i] >= filt_thresh) begin
               filt_d[i] = cond[i];
               cnt_d[i]  = '0;
            end else begin
               cnt_d[i] = cnt_q[i] + FILT_WIDTH'(1);
            end
         end
      end
   end

   always_ff @(posedge kplic_clk or negedge kplic_rstn) begin
      if (!kplic_rstn) begin
         cnt_q  <= '0;
         filt_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         filt_q <= filt_d;
      end
   end

   assign external_int = ready ? filt_q : '0;
`else
   logic [INT_NUM-1:0] ext_q;
   logic               unused_thresh;

   always_ff @(posedge kplic_clk or negedge kplic_rstn) begin
      if (!kplic_rstn) begin
         ext_q <= '0;
      end else begin
         ext_q <= ready ? cond : '0;
      end
   end

   assign external_int  = ext_q;
   assign unused_thresh = ^filt_thresh;
`endif

endmodule

// File: tb/tb_kplic_int_conditioner.sv
// Directed, scoreboard-checked bench for kplic_int_conditioner; expectations follow
// the KPLIC_INT_FILTER_EN setting of the build.
`timescale 1ns/1ps
module tb_kplic_int_conditioner;

`ifdef KPLIC_INT_FILTER_EN
   localparam int FILT_ON = 1;
`else
   localparam int FILT_ON = 0;
`endif

   logic        kplic_clk;
   logic        kplic_rstn;
   logic [31:0] raw_int;
   logic [31:0] int_polarity;
   logic [3:0]  filt_thresh;
   logic [31:0] external_int;
   logic [31:0] int_status;

   int errors = 0;
   int checks = 0;

   logic [31:0] expStatusQ[$];
   logic [31:0] expExtQ[$];

   // Reference model state: edges since reset release, raw history, filter state.
   int          edgeN;
   logic [31:0] hist1;
   logic [31:0] hist2;
   logic [31:0] mFilt;
   logic [3:0]  mCnt [32];

   logic        tS [1:32];
   logic        tE [1:32];
   int          lat;

   kplic_int_conditioner #(.INT_NUM(32), .FILT_WIDTH(4)) dut (
      .kplic_clk    (kplic_clk),
      .kplic_rstn   (kplic_rstn),
      .raw_int      (raw_int),
      .int_polarity (int_polarity),
      .filt_thresh  (filt_thresh),
      .external_int (external_int),
      .int_status   (int_status)
   );

   initial kplic_clk = 1'b0;
   always #5 kplic_clk = ~kplic_clk;

   task automatic modelReset();
      edgeN = 0;
      hist1 = '0;
      hist2 = '0;
      mFilt = '0;
      for (int i = 0; i < 32; i++) mCnt[i] = '0;
   endtask

   // Drives one cycle of inputs and pushes the outputs expected after the next edge.
   task automatic applyStimulus(input logic [31:0] raw, input logic [31:0] pol, input logic [3:0] thr);
      logic [31:0] condE;
      logic [31:0] expS;
      logic [31:0] expE;
      int          n;
      raw_int      = raw;
      int_polarity = pol;
      filt_thresh  = thr;
      n     = edgeN + 1;
      condE = hist2 ^ pol;
      expS  = (n >= 2) ? (hist1 ^ pol) : '0;
`ifdef KPLIC_INT_FILTER_EN
      if (n < 3) begin
         mFilt = '0;
         for (int i = 0; i < 32; i++) mCnt[i] = '0;
      end else begin
         for (int i = 0; i < 32; i++) begin
            if (condE[i] == mFilt[i]) begin
               mCnt[i] = '0;
            end else if (mCnt[i] >= thr) begin
               mFilt[i] = condE[i];
               mCnt[i]  = '0;
            end else begin
               mCnt[i] = mCnt[i] + 4'd1;
            end
         end
      end
      expE = mFilt;
`else
      expE = (n >= 3) ? condE : '0;
`endif
      hist2 = hist1;
      hist1 = raw;
      edgeN = n;
      expStatusQ.push_back(expS);
      expExtQ.push_back(expE);
   endtask

   task automatic compareNow(input string tag);
      logic [31:0] eS;
      logic [31:0] eE;
      if (expStatusQ.size() == 0 || expExtQ.size() == 0) begin
         checks++;
         errors++;
         $error("[TB] FAIL %s scoreboard empty observed=none expected=entry", tag);
      end else begin
         eS = expStatusQ.pop_front();
         eE = expExtQ.pop_front();
         checks++;
         assert (int_status === eS) else begin
            errors++;
            $error("[TB] FAIL %s int_status observed=%h expected=%h", tag, int_status, eS);
         end
         checks++;
         assert (external_int === eE) else begin
            errors++;
            $error("[TB] FAIL %s external_int observed=%h expected=%h", tag, external_int, eE);
         end
      end
   endtask

   task automatic checkOutput(input string tag);
      @(posedge kplic_clk);
      #1;
      compareNow(tag);
   endtask

   task automatic expectBit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic expectVec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Asserts reset between edges, checks the asynchronous clear, then releases it.
   task automatic doReset(input logic [31:0] raw, input logic [31:0] pol, input logic [3:0] thr, input string tag);
      raw_int      = raw;
      int_polarity = pol;
      filt_thresh  = thr;
      kplic_rstn   = 1'b0;
      #1;
      expStatusQ.push_back('0);
      expExtQ.push_back('0);
      compareNow({tag, "_async"});
      modelReset();
      repeat (2) begin
         expStatusQ.push_back('0);
         expExtQ.push_back('0);
         checkOutput({tag, "_held"});
      end
      kplic_rstn = 1'b1;
   endtask

   // Inverts bit idx of base for the first width cycles, recording that bit's outputs.
   task automatic runPulse(input int idx, input int width, input int total, input logic [31:0] pol,
                           input logic [3:0] thr, input logic [31:0] base, input string tag);
      logic [31:0] r;
      for (int k = 1; k <= total; k++) begin
         r      = base;
         r[idx] = (k <= width) ? ~base[idx] : base[idx];
         applyStimulus(r, pol, thr);
         checkOutput(tag);
         tS[k] = int_status[idx];
         tE[k] = external_int[idx];
      end
   endtask

   initial begin
      logic anyE;
      kplic_rstn   = 1'b1;
      raw_int      = '1;
      int_polarity = '1;
      filt_thresh  = '0;
      modelReset();
      #2;

      // Reset/settle: active-low sources idling high must never show up.
      doReset('1, '1, 4'd0, "rst_init");
      for (int k = 0; k < 6; k++) begin
         applyStimulus('1, '1, 4'd0);
         checkOutput("settle");
         expectVec("settle_ext_zero", external_int, '0);
         expectVec("settle_status_zero", int_status, '0);
      end

      // Basic propagation with threshold 0.
      runPulse(5, 0, 6, '0, 4'd0, '0, "idle_a");
      lat = 3;
      runPulse(5, 6, 14, '0, 4'd0, '0, "basic");
      expectBit("basic_status_e1", tS[1], 1'b0);
      expectBit("basic_status_e2", tS[2], 1'b1);
      expectBit("basic_ext_before", tE[lat - 1], 1'b0);
      expectBit("basic_ext_rise", tE[lat], 1'b1);
      expectBit("basic_status_fall", tS[8], 1'b0);
      expectBit("basic_ext_hold", tE[6 + lat - 1], 1'b1);
      expectBit("basic_ext_fall", tE[6 + lat], 1'b0);

      // Glitch rejection with threshold 3.
      runPulse(0, 0, 4, '0, 4'd3, '0, "idle_b");
      runPulse(0, 3, 12, '0, 4'd3, '0, "glitch3");
`ifdef KPLIC_INT_FILTER_EN
      anyE = 1'b0;
      for (int k = 1; k <= 12; k++) anyE = anyE | tE[k];
      expectBit("glitch3_rejected", anyE, 1'b0);
`else
      expectBit("glitch3_pass_e2", tE[2], 1'b0);
      expectBit("glitch3_pass_e3", tE[3], 1'b1);
      expectBit("glitch3_pass_e6", tE[6], 1'b0);
`endif
      lat = 3 + FILT_ON * 3;
      runPulse(0, 4, 14, '0, 4'd3, '0, "glitch4");
      expectBit("glitch4_before", tE[lat - 1], 1'b0);
      expectBit("glitch4_rise", tE[lat], 1'b1);
      expectBit("glitch4_hold", tE[lat + 3], 1'b1);
      expectBit("glitch4_fall", tE[lat + 4], 1'b0);

      // Polarity: active-low line 31 driven 1 -> 0.
      runPulse(31, 0, 6, 32'h8000_0000, 4'd2, 32'h8000_0000, "idle_c");
      lat = 3 + FILT_ON * 2;
      runPulse(31, 10, 10, 32'h8000_0000, 4'd2, 32'h8000_0000, "polarity");
      expectBit("pol_status_e1", tS[1], 1'b0);
      expectBit("pol_status_e2", tS[2], 1'b1);
      expectBit("pol_ext_before", tE[lat - 1], 1'b0);
      expectBit("pol_ext_rise", tE[lat], 1'b1);
      runPulse(31, 0, 6, '0, 4'd2, '0, "idle_d");

      // Mid-count threshold drop from 15 to 2.
      runPulse(7, 0, 4, '0, 4'd15, '0, "idle_e");
      runPulse(7, 7, 7, '0, 4'd15, '0, "thresh15");
`ifdef KPLIC_INT_FILTER_EN
      expectBit("thresh15_still_low", tE[7], 1'b0);
`else
      expectBit("nofilt_ext_e2", tE[2], 1'b0);
      expectBit("nofilt_ext_e3", tE[3], 1'b1);
`endif
      applyStimulus(32'h0000_0080, '0, 4'd2);
      checkOutput("thresh_drop");
      expectBit("thresh_drop_update", external_int[7], 1'b1);

      // Asynchronous reset mid-pulse, then settle again with the line still high.
      doReset(32'h0000_0080, '0, 4'd2, "rst_mid");
      expectVec("rst_mid_ext_zero", external_int, '0);
      lat = 3 + FILT_ON * 2;
      runPulse(7, 8, 8, '0, 4'd2, '0, "resettle");
      expectBit("resettle_status_e1", tS[1], 1'b0);
      expectBit("resettle_status_e2", tS[2], 1'b1);
      expectBit("resettle_ext_before", tE[lat - 1], 1'b0);
      expectBit("resettle_ext_rise", tE[lat], 1'b1);

      // Single-cycle pulse with threshold 7.
      runPulse(10, 0, 14, '0, 4'd7, '0, "idle_f");
      runPulse(10, 1, 8, '0, 4'd7, '0, "pulse1");
`ifdef KPLIC_INT_FILTER_EN
      anyE = 1'b0;
      for (int k = 1; k <= 8; k++) anyE = anyE | tE[k];
      expectBit("pulse1_rejected", anyE, 1'b0);
`else
      expectBit("pulse1_e2", tE[2], 1'b0);
      expectBit("pulse1_e3", tE[3], 1'b1);
      expectBit("pulse1_e4", tE[4], 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/kplic_int_conditioner.md
# kplic_int_conditioner

Input conditioning stage directly upstream of the KPLIC: takes raw, asynchronous external interrupt lines from peripherals and pads. It synchronises each line into the KPLIC clock domain, applies per-line polarity, and optionally glitch-filters it. It drives the KPLIC `external_int` bus with clean, active-high, single-clock-domain levels. The per-source gateways (level/edge handling, enable, completion) remain downstream and are unchanged.

## Interface
Parameters:
- `INT_NUM`, 32, number of interrupt lines; must equal the KPLIC source count.
- `FILT_WIDTH`, 4, width of the per-line filter counter and of `filt_thresh`.

Ports:
- `kplic_clk` input 1: KPLIC clock; the only clock of the block.
- `kplic_rstn` input 1: reset, asynchronous, active-low.
- `raw_int` input INT_NUM: raw interrupt lines, asynchronous to `kplic_clk`.
- `int_polarity` input INT_NUM: per-line polarity, quasi-static. 1 = source is active-low (inverted); 0 = active-high.
- `filt_thresh` input FILT_WIDTH: glitch filter threshold, quasi-static. Ignored when the filter is compiled out.
- `external_int` output INT_NUM: conditioned active-high lines; connects to the KPLIC `external_int`.
- `int_status` output INT_NUM: unfiltered, polarity-corrected synchronised level. Used for register readback and debug.

## Operation
- **Synchroniser.** Each line has a 2-flop chain, `sync1` then `sync2`. Both flops reset to 0.
- **Settle counter.** A 2-bit counter starts at 0 on reset and increments once per clock until it reaches 2, where it saturates.
  - `ready` = (counter == 2), i.e. 2 edges after reset release.
  - While `ready` = 0, every per-line filter counter and `filt_q` is held at 0, and both outputs are forced to 0.
  - Purpose: an active-low source idling high does not produce a spurious assertion while the sync chain fills.
- **Polarity.** `cond[i] = sync2[i] ^ int_polarity[i]`.
  - `int_status = ready ? cond : 0`. This is combinational from flops.
- **Filter, per line (only when compiled in).**
  - State: FILT_WIDTH-bit counter `cnt` and 1-bit `filt_q`.
  - If `cond == filt_q`: `cnt <= 0`.
  - Else if `cnt >= filt_thresh`: `filt_q <= cond` and `cnt <= 0`.
  - Else: `cnt <= cnt + 1`.
  - `cnt` never exceeds `filt_thresh`, so it cannot wrap.
  - The `>=` comparison means that lowering `filt_thresh` mid-count causes an update on the next mismatching cycle.
  - `external_int = filt_q`.
- The filter is symmetric: assertion and deassertion are filtered identically.
- No handshake with the KPLIC. The output is a level; the gateway performs edge/level interpretation.

## Timing
- **Reset values:** `external_int` = 0 and `int_status` = 0 (all bits), held until `ready` plus the pipeline delay.
- **Latency, raw change to `int_status`:** 2 edges (edge 1 → `sync1`, edge 2 → `sync2`).
- **Latency, raw change to `external_int`:**
  - 3 + `filt_thresh` edges with the filter compiled in.
  - Fixed 3 edges without it.
- **Minimum pulse width:**
  - A `cond` pulse shorter than `filt_thresh` + 1 cycles is rejected entirely.
  - A pulse of at least `filt_thresh` + 1 cycles propagates.
- **Toggle during filtering:** if `cond` returns to `filt_q` before the threshold is reached, `cnt` clears and no output change occurs.
- **Reset mid-operation:** asynchronous clear of all flops, counters and `filt_q`. Outputs go to 0 immediately. The settle sequence restarts on release.
- **`int_polarity` change:** treated as a `cond` change. It is filtered like any input transition, with no extra glitch protection.

## Configuration
- Macro: `KPLIC_INT_FILTER_EN`.
- **Defined:**
  - Per-line counters and `filt_q` are instantiated as described in Operation.
  - `filt_thresh` is honoured.
- **Undefined:**
  - No counters are instantiated.
  - `external_int` is a single flop per line: `external_int <= ready ? cond : 0`.
  - Latency is a fixed 3 edges.
  - `filt_thresh` is unused.
  - `int_status` is unchanged from the filtered build.

## Test plan
- **Reset/settle.** `int_polarity` = all 1, `raw_int` = all 1, release reset.
  - Required: `external_int` and `int_status` remain 0 on every cycle.
- **Basic propagation, filter in.** `filt_thresh` = 0, `int_polarity` = 0, raise `raw_int[5]`.
  - Required: `int_status[5]` = 1 after edge 2.
  - Required: `external_int[5]` = 1 after edge 3.
  - Required: lowering it again produces the same 3-edge fall latency.
- **Glitch rejection.** `filt_thresh` = 3.
  - A 3-cycle high pulse on `raw_int[0]`: `external_int[0]` stays 0.
  - A 4-cycle pulse: `external_int[0]` rises exactly 6 edges after the raw rise and falls 6 edges after the raw fall.
- **Polarity.** `int_polarity[31]` = 1, `raw_int[31]` driven 1 → 0.
  - Required: `external_int[31]` goes 0 → 1 after 3 + `filt_thresh` edges.
  - Required: `int_status[31]` follows after 2 edges.
- **Mid-count threshold change and async reset.** `filt_thresh` = 15, hold a mismatch for 5 cycles, then write `filt_thresh` = 2.
  - Required: output updates on the next edge.
  - Then assert `kplic_rstn` mid-pulse: outputs go to 0 asynchronously, and the settle sequence repeats after release.
- **Macro off.** Build without `KPLIC_INT_FILTER_EN`, `filt_thresh` = 7.
  - A 1-cycle pulse on `raw_int[10]` appears on `external_int[10]` as a 1-cycle pulse 3 edges later.
